// File: rtl/mux4_rr_sched_if.sv
// Handshake bundle between the four requesters, the 4:1 mux select and the output channel.
interface mux4_rr_sched_if #(
  parameter int W = 1
);
  logic [3:0]     req;
  logic [4*W-1:0] din;
  logic           rdy;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic [3:0]     ack;
  logic           vld;
  logic [W-1:0]   y;

  modport master (output req, din, rdy, input gnt, sel, ack, vld, y);
  modport slave  (input req, din, rdy, output gnt, sel, ack, vld, y);
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin 4:1 output scheduler: grant 1 cycle after IDLE sees req, y/vld 1 cycle after ack; holds everything while vld && !rdy.
// Build with MUX4_RR_SCHED_HOLD_EN for bursts of up to MAX_HOLD beats per grant; otherwise one beat per grant.
module mux4_rr_sched #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux4_rr_sched_if.slave bus
);
`ifdef MUX4_RR_SCHED_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  localparam logic [3:0] LIMIT = HOLD_EN ? 4'(MAX_HOLD) : 4'd1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  logic [1:0]   ptr;
  logic [1:0]   win;
  logic [1:0]   idx;
  logic [3:0]   cnt;
  logic         le;
  logic         cap;
  logic         last;
  logic [W-1:0] lane_dat;

  assign le       = !bus.vld || bus.rdy;
  // ack must not claim a capture on an edge that reset will discard
  assign cap      = !rst && (state == GRANT) && le && bus.req[bus.sel];
  assign bus.ack  = cap ? (4'b0001 << bus.sel) : 4'b0000;
  assign lane_dat = bus.din[bus.sel*W +: W];
  assign last     = !bus.req[bus.sel] || ((cnt + 4'd1) == LIMIT);

  // Scan downwards so the lane closest to ptr is the final assignment.
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      bus.gnt <= '0;
      bus.sel <= '0;
      bus.vld <= 1'b0;
      bus.y   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.vld && bus.rdy) bus.vld <= 1'b0;
          if (|bus.req) begin
            state   <= GRANT;
            bus.gnt <= 4'b0001 << win;
            bus.sel <= win;
            cnt     <= '0;
          end
        end
        GRANT: begin
          if (le) begin
            if (bus.req[bus.sel]) begin
              bus.y   <= lane_dat;
              bus.vld <= 1'b1;
              cnt     <= cnt + 4'd1;
            end else begin
              bus.vld <= 1'b0;
            end
            if (last) begin
              state   <= IDLE;
              bus.gnt <= '0;
              ptr     <= bus.sel + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Randomized and directed bench for mux4_rr_sched against a lane-level reference model and beat scoreboard.
module tb_mux4_rr_sched;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
`ifdef MUX4_RR_SCHED_HOLD_EN
  localparam int LIMIT = MAX_HOLD;
`else
  localparam int LIMIT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux4_rr_sched_if #(.W(W)) bus ();
  mux4_rr_sched #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: granted lane as an int (-1 = idle), beats in this grant, rotation start.
  int           m_cur;
  int           m_ptr;
  int           m_cnt;
  int           m_sel;
  int           m_wait [4];
  bit           m_vld;
  logic [W-1:0] m_y;
  logic [W-1:0] sb [$];
  logic [3:0]   last_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return bus.din[i*W +: W];
  endfunction

  function automatic int lane_of(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_cur = -1; m_ptr = 0; m_cnt = 0; m_sel = 0; m_vld = 1'b0; m_y = '0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) if (!bus.req[i]) m_wait[i] = 0;
    if (m_cur < 0) begin
      if (m_vld && bus.rdy) m_vld = 1'b0;
      if (bus.req != 4'b0) begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && bus.req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        for (int i = 0; i < 4; i++) begin
          if (i == w) m_wait[i] = 0;
          else if (bus.req[i]) begin
            m_wait[i]++;
            check("fair_wait", 32'(m_wait[i] <= 3), 32'd1);
          end
        end
        m_cur = w; m_sel = w; m_cnt = 0;
      end
    end else if (!m_vld || bus.rdy) begin
      if (bus.req[m_cur]) begin
        m_y = lane(m_cur); m_vld = 1'b1; m_cnt++;
        if (m_cnt == LIMIT) begin m_ptr = (m_cur + 1) % 4; m_cur = -1; end
      end else begin
        m_vld = 1'b0; m_ptr = (m_cur + 1) % 4; m_cur = -1;
      end
    end
  endtask

  // One clock: check ack with inputs settled, score the output beat, advance model, check registers.
  task automatic cyc();
    logic [3:0] ea;
    #1;
    ea = 4'b0;
    if (!rst && m_cur >= 0 && (!m_vld || bus.rdy) && bus.req[m_cur]) ea = 4'(1 << m_cur);
    check("ack", 32'(bus.ack), 32'(ea));
    last_ack = bus.ack;
    if (rst) sb.delete();
    else begin
      if (bus.vld && bus.rdy) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check("sb_beat", 32'(bus.y), 32'(sb.pop_front()));
      end
      if (ea != 4'b0) sb.push_back(lane(m_cur));
    end
    @(posedge clk);
    model_edge();
    #1;
    check("gnt", 32'(bus.gnt), (m_cur < 0) ? 32'd0 : 32'(1 << m_cur));
    check("sel", 32'(bus.sel), 32'(m_sel));
    check("vld", 32'(bus.vld), 32'(m_vld));
    check("y", 32'(bus.y), 32'(m_y));
  endtask

  task automatic reset_cycle();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  initial begin
    int cnt_g, k, acks, target;
    logic [3:0] prevg;
    bit ok, seen0;

    model_reset();
    rst = 1'b1; bus.rdy = 1'($urandom); bus.req = 4'($urandom); bus.din = 32'($urandom);
    cyc();
    bus.req = 4'($urandom); bus.din = 32'($urandom);
    cyc();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_vld", 32'(bus.vld), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    rst = 1'b0;

    // Single lane: burst length and one-cycle bubble before re-grant.
    bus.req = 4'b0100; bus.rdy = 1'b1; bus.din = 32'($urandom); bus.din[2*W +: W] = 8'hA5;
    cnt_g = 0;
    for (int c = 0; c < LIMIT + 1; c++) begin
      cyc();
      if (bus.gnt == 4'b0100) cnt_g++;
    end
    check("burst_len", 32'(cnt_g), 32'(LIMIT));
    check("bubble_gnt", 32'(bus.gnt), 32'd0);
    check("last_y", 32'(bus.y), 32'hA5);
    cyc();
    check("regrant", 32'(bus.gnt), 32'b0100);

    // Round robin with all lanes requesting.
    reset_cycle();
    bus.req = 4'b1111; bus.rdy = 1'b1;
    prevg = 4'b0; k = 0;
    for (int c = 0; c < 200 && k < 5; c++) begin
      cyc();
      if (bus.gnt != 4'b0 && prevg == 4'b0) begin
        check("rr_order", 32'(lane_of(bus.gnt)), 32'(k % 4));
        k++;
      end
      prevg = bus.gnt;
    end
    check("rr_grants", 32'(k), 32'd5);

    // Early release by lane 1, then lane 3 must win from ptr=2.
    reset_cycle();
    bus.req = 4'b0010; bus.rdy = 1'b1;
    target = (LIMIT < 2) ? 1 : 2;
    acks = 0; ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      cyc();
      if (last_ack[1]) acks++;
      if (acks == target) ok = 1'b1;
    end
    check("release_acks", 32'(ok), 32'd1);
    bus.req = 4'b1001;
    seen0 = (bus.gnt == 4'b0); ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      cyc();
      if (bus.gnt == 4'b0) seen0 = 1'b1;
      else if (seen0) ok = 1'b1;
    end
    check("release_next", 32'(bus.gnt), 32'b1000);

    // Backpressure for 3 cycles mid-transfer.
    reset_cycle();
    bus.req = 4'b1111; bus.rdy = 1'b1; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      bus.din = 32'($urandom); cyc(); ok = bus.vld;
    end
    check("bp_vld_seen", 32'(ok), 32'd1);
    bus.rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin bus.din = 32'($urandom); cyc(); end
    bus.rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin bus.din = 32'($urandom); cyc(); end

    // Reset while a beat is stalled at the output.
    reset_cycle();
    bus.req = 4'b1111; bus.rdy = 1'b0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin cyc(); ok = bus.vld; end
    check("mr_vld_seen", 32'(ok), 32'd1);
    rst = 1'b1; cyc();
    check("mr_vld", 32'(bus.vld), 32'd0);
    check("mr_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b0; ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin cyc(); ok = (bus.gnt != 4'b0); end
    check("mr_first", 32'(bus.gnt), 32'b0001);

    // Random traffic with sticky requests, random backpressure and rare resets.
    bus.rdy = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) bus.req[i] = ~bus.req[i];
      bus.din = 32'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
